// File: rtl/im_load_controller.sv
// rtl/im_load_controller.sv - byte-stream instruction memory loader with CPU fetch mux
module im_load_controller #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic [ADDR_W:0]   load_len,
  input  logic              load_byte_valid,
  input  logic [7:0]        load_byte,
  output logic              load_byte_ready,
  output logic              load_busy,
  output logic              load_done,
  input  logic [31:0]       cpu_pc,
  output logic [31:0]       cpu_instr,
  output logic              cpu_stall,
  output logic [31:0]       im_addr,
  output logic [31:0]       im_wdata,
  output logic              im_we,
  input  logic [31:0]       im_rdata
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RECV  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  // Largest session length the memory can hold; longer requests are clamped.
  localparam logic [ADDR_W:0] MAX_LEN = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE     = (ADDR_W+1)'(1);

  logic [1:0]      state;
  logic [ADDR_W:0] len_q;
  logic [ADDR_W:0] word_cnt;
  logic [1:0]      byte_cnt;
  logic [31:0]     word_buf;

  logic            byte_hs;
  logic [ADDR_W:0] word_nxt;
  logic [ADDR_W:0] len_clamped;

  assign byte_hs     = (state == RECV) && load_byte_valid;
  assign word_nxt    = word_cnt + ONE;
  assign len_clamped = (load_len > MAX_LEN) ? MAX_LEN : load_len;

  // Session FSM, counters and big-endian word assembly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      len_q    <= '0;
      word_cnt <= '0;
      byte_cnt <= 2'd0;
      word_buf <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (load_start) begin
            len_q    <= len_clamped;
            word_cnt <= '0;
            byte_cnt <= 2'd0;
            state    <= (len_clamped == '0) ? DONE : RECV;
          end
        end
        RECV: begin
          if (byte_hs) begin
            word_buf <= {word_buf[23:0], load_byte};
            if (byte_cnt == 2'd3) begin
              byte_cnt <= 2'd0;
              state    <= WRITE;
            end else begin
              byte_cnt <= byte_cnt + 2'd1;
            end
          end
        end
        WRITE: begin
          word_cnt <= word_nxt;
          state    <= (word_nxt == len_q) ? DONE : RECV;
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Status outputs and memory port mux: CPU owns the memory only while idle.
  always_comb begin
    load_byte_ready = (state == RECV);
    load_busy       = (state != IDLE);
    load_done       = (state == DONE);
    cpu_stall       = (state != IDLE);
    im_we           = (state == WRITE);
    im_wdata        = word_buf;
    if (state == IDLE) begin
      im_addr   = cpu_pc;
      cpu_instr = im_rdata;
    end else begin
      im_addr   = {{(32-ADDR_W){1'b0}}, word_cnt[ADDR_W-1:0]};
      cpu_instr = 32'h0000_0000;
    end
  end

endmodule

// File: tb/tb_im_load_controller.sv
// tb/tb_im_load_controller.sv - self-checking bench for im_load_controller
module tb_im_load_controller;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          load_start;
  logic [AW:0]   load_len;
  logic          load_byte_valid;
  logic [7:0]    load_byte;
  logic          load_byte_ready;
  logic          load_busy;
  logic          load_done;
  logic [31:0]   cpu_pc;
  logic [31:0]   cpu_instr;
  logic          cpu_stall;
  logic [31:0]   im_addr;
  logic [31:0]   im_wdata;
  logic          im_we;
  logic [31:0]   im_rdata;

  im_load_controller #(.DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .load_start(load_start), .load_len(load_len),
    .load_byte_valid(load_byte_valid), .load_byte(load_byte),
    .load_byte_ready(load_byte_ready), .load_busy(load_busy), .load_done(load_done),
    .cpu_pc(cpu_pc), .cpu_instr(cpu_instr), .cpu_stall(cpu_stall),
    .im_addr(im_addr), .im_wdata(im_wdata), .im_we(im_we), .im_rdata(im_rdata)
  );

  always #5 clk = ~clk;

  // Instruction memory: synchronous write, combinational read.
  logic [31:0] mem [DEPTH];
  logic        mem_init = 1'b0;
  assign im_rdata = mem[im_addr[AW-1:0]];
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 32'h0;
      mem_init <= 1'b1;
    end else if (im_we) begin
      mem[im_addr[AW-1:0]] <= im_wdata;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Observed writes and done pulses, plus continuous output invariants.
  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int done_cnt = 0;
  int done_cyc = 0;
  int last_we_cyc = 0;
  int mon_bad = 0;
  always @(negedge clk) begin
    if (im_we) begin
      wr_addr_q.push_back(im_addr);
      wr_data_q.push_back(im_wdata);
      last_we_cyc = cyc;
    end
    if (load_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (!rst) begin
      if (cpu_stall !== load_busy) mon_bad++;
      if (load_busy && cpu_instr !== 32'h0) mon_bad++;
      if (im_we && load_byte_ready) mon_bad++;
      if (load_done && !load_busy) mon_bad++;
    end
  end

  int tests = 0;
  int failed = 0;
  logic [31:0] model_mem [DEPTH];
  logic [7:0]  byte_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic readback();
    for (int a = 0; a < DEPTH; a++) begin
      cpu_pc = 32'(a);
      #1;
      check($sformatf("fetch[%0d]", a), cpu_instr, model_mem[a]);
    end
    check("fetch_stall", {31'h0, cpu_stall}, 32'h0);
    @(negedge clk);
  endtask

  // Transfer one byte; returns at the negedge after it has been consumed.
  task automatic send_byte(input logic [7:0] b);
    int n;
    load_byte = b;
    load_byte_valid = 1'b1;
    n = 0;
    while (!load_byte_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("byte_ready_timeout", 32'h1, 32'h0);
    @(negedge clk);
    load_byte_valid = 1'b0;
  endtask

  // One load session; byte_q is used as-is when fixed=1, else filled randomly.
  task automatic do_session(input int len, input int gap, input int restart_at,
                            input bit fixed, input int exp_writes);
    int eff, base_w, base_d, n;
    eff = (len > DEPTH) ? DEPTH : len;
    if (!fixed) begin
      byte_q.delete();
      for (int i = 0; i < eff * 4; i++) byte_q.push_back(8'($urandom));
    end
    for (int i = 0; i < eff; i++)
      model_mem[i] = {byte_q[4*i], byte_q[4*i+1], byte_q[4*i+2], byte_q[4*i+3]};
    base_w = wr_addr_q.size();
    base_d = done_cnt;
    load_len = 5'(len);
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    check("busy_after_start", {31'h0, load_busy}, 32'h1);
    if (eff == 0) check("done_len0", {31'h0, load_done}, 32'h1);
    for (int i = 0; i < eff * 4; i++) begin
      if (i == restart_at) begin
        load_start = 1'b1;
        load_len = 5'd1;
      end
      send_byte(byte_q[i]);
      load_start = 1'b0;
      repeat (gap) @(negedge clk);
    end
    n = 0;
    while (load_busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("session_end_timeout", {31'h0, load_busy}, 32'h0);
    check("write_count", 32'(wr_addr_q.size() - base_w), 32'(exp_writes));
    for (int i = 0; i < eff && base_w + i < wr_addr_q.size(); i++) begin
      check($sformatf("wr_addr[%0d]", i), wr_addr_q[base_w+i], 32'(i));
      check($sformatf("wr_data[%0d]", i), wr_data_q[base_w+i], model_mem[i]);
    end
    check("done_pulses", 32'(done_cnt - base_d), 32'h1);
    if (eff > 0) check("done_after_last_write", 32'(done_cyc - last_we_cyc), 32'h1);
    readback();
  endtask

  typedef struct {
    int len;
    int gap;
    int exp_writes;
  } vec_t;
  vec_t tbl[6];

  initial begin
    tbl[0] = '{len: 1,  gap: 0, exp_writes: 1};
    tbl[1] = '{len: 3,  gap: 1, exp_writes: 3};
    tbl[2] = '{len: 16, gap: 0, exp_writes: 16};
    tbl[3] = '{len: 20, gap: 0, exp_writes: 16};
    tbl[4] = '{len: 31, gap: 2, exp_writes: 16};
    tbl[5] = '{len: 5,  gap: 0, exp_writes: 5};

    for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;
    rst = 1'b1;
    load_start = 1'b0;
    load_len = '0;
    load_byte_valid = 1'b0;
    load_byte = 8'h0;
    cpu_pc = 32'h0;
    #1;
    check("rst_ready", {31'h0, load_byte_ready}, 32'h0);
    check("rst_busy",  {31'h0, load_busy}, 32'h0);
    check("rst_done",  {31'h0, load_done}, 32'h0);
    check("rst_we",    {31'h0, im_we}, 32'h0);
    check("rst_stall", {31'h0, cpu_stall}, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reference two-word program, back-to-back bytes.
    byte_q = '{8'h20, 8'h11, 8'h00, 8'h05, 8'h8C, 8'h02, 8'h00, 8'h04};
    do_session(2, 0, -1, 1'b1, 2);
    cpu_pc = 32'h1;
    #1;
    check("pc1_instr", cpu_instr, 32'h8C02_0004);
    check("pc1_stall", {31'h0, cpu_stall}, 32'h0);
    cpu_pc = 32'h0;
    #1;
    check("pc0_instr", cpu_instr, 32'h2011_0005);
    @(negedge clk);

    // Same program with 3-cycle gaps, CPU pointing at a non-zero word.
    cpu_pc = 32'h1;
    do_session(2, 3, -1, 1'b1, 2);

    // Zero-length session: IDLE -> DONE -> IDLE.
    do_session(0, 0, -1, 1'b0, 0);
    check("len0_idle_after", {31'h0, load_done}, 32'h0);

    // Restart request during RECV is ignored; valid is held across WRITE.
    do_session(2, 0, 2, 1'b0, 2);

    for (int v = 0; v < 6; v++)
      do_session(tbl[v].len, tbl[v].gap, -1, 1'b0, tbl[v].exp_writes);

    // Reset after six bytes of a two-word load.
    byte_q.delete();
    for (int i = 0; i < 8; i++) byte_q.push_back(8'($urandom));
    model_mem[0] = {byte_q[0], byte_q[1], byte_q[2], byte_q[3]};
    load_len = 5'd2;
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    for (int i = 0; i < 6; i++) send_byte(byte_q[i]);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_ready", {31'h0, load_byte_ready}, 32'h0);
    check("midrst_busy",  {31'h0, load_busy}, 32'h0);
    check("midrst_done",  {31'h0, load_done}, 32'h0);
    check("midrst_we",    {31'h0, im_we}, 32'h0);
    check("midrst_stall", {31'h0, cpu_stall}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    readback();
    do_session(2, 0, -1, 1'b0, 2);

    // Randomised sessions against the model.
    for (int r = 0; r < 6; r++) begin
      int len, gap;
      len = $urandom_range(0, 31);
      gap = $urandom_range(0, 2);
      do_session(len, gap, -1, 1'b0, (len > DEPTH) ? DEPTH : len);
    end

    check("output_invariants", 32'(mon_bad), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
